// File: rtl/break_pkg.sv
// -----------------------------------------------------------------------------
// break_pkg
// Shared definitions for the break scheduler and its request arbiter.
//   state_t          : scheduler FSM states and their fixed debug encodings
//   DEF_*            : default values for the break_sched parameters
//   grant_w()        : width of a source index for n requesters
//   cnt_w()          : width of the shared timeout / run-window counter
// -----------------------------------------------------------------------------
package break_pkg;

    // Encodings are visible on debug_state, so they are pinned explicitly.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BREAK   = 3'd1,
        ST_SERVICE = 3'd2,
        ST_RESUME  = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_MIN_RUN      = 16;
    localparam int DEF_HALT_TIMEOUT = 1024;

    // Index width for n sources; never narrower than one bit.
    function automatic int grant_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // One extra bit over the larger terminal count so neither load value
    // nor the timeout compare can wrap.
    function automatic int cnt_w(input int min_run, input int halt_timeout);
        int m;
        m = (min_run > halt_timeout) ? min_run : halt_timeout;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: returns the first set request at or above
// the priority pointer, wrapping past the top index back to 0.
//   N    : number of requesters
//   req  : request vector, bit i = source i
//   ptr  : index with highest priority this pick
//   any  : at least one request is set
//   idx  : index of the winning request (0 when any = 0)
// The pointer update is left to the user so the same block can serve
// arbiters with different advance rules.
// -----------------------------------------------------------------------------
module rr_arbiter
    import break_pkg::*;
#(
    parameter int N = DEF_NUM_REQ
) (
    input  logic [N-1:0]          req,
    input  logic [grant_w(N)-1:0] ptr,
    output logic                  any,
    output logic [grant_w(N)-1:0] idx
);

    localparam int W = grant_w(N);
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cand;

    // Walk the candidates in priority order starting at ptr; the first hit
    // wins and later hits are ignored.
    // NOTE: every variable written here gets a value before any branch,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = ptr;
        for (int i = 0; i < N; i++) begin
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
            cand = (cand == LAST) ? '0 : cand + W'(1);
        end
    end

endmodule

// File: rtl/break_sched.sv
// -----------------------------------------------------------------------------
// break_sched
// Central scheduler for debug / co-simulation breaks. Level requests from
// NUM_REQ sources are round-robin arbitrated; the winner halts the core via
// break_out/halted, is handed to the host for service, then the core is
// resumed with turn2run and allowed to run at least MIN_RUN cycles before
// the next break.
//
// Parameters
//   NUM_REQ      : number of break requesters (2..8)
//   MIN_RUN      : guaranteed run cycles after resume (>=1)
//   HALT_TIMEOUT : cycles to wait for halted before aborting a break (>=2)
//
// Ports
//   clk          : system clock
//   resetn       : asynchronous active-low reset
//   req          : level break requests, bit i = source i
//   halted       : core is stopped at a break (level)
//   svc_done     : one-cycle pulse, host finished servicing grant_id
//   err_clr      : one-cycle pulse, clears timeout_err
//   break_out    : break request to the core
//   grant_valid  : host should service grant_id
//   grant_id     : index of the granted source
//   turn2run     : one-cycle resume pulse to the core
//   busy         : scheduler is not idle
//   timeout_err  : sticky halt-timeout flag
//   debug_state  : current state encoding
// -----------------------------------------------------------------------------
module break_sched
    import break_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int MIN_RUN      = DEF_MIN_RUN,
    parameter int HALT_TIMEOUT = DEF_HALT_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [NUM_REQ-1:0]          req,
    input  logic                        halted,
    input  logic                        svc_done,
    input  logic                        err_clr,
    output logic                        break_out,
    output logic                        grant_valid,
    output logic [grant_w(NUM_REQ)-1:0] grant_id,
    output logic                        turn2run,
    output logic                        busy,
    output logic                        timeout_err,
    output logic [2:0]                  debug_state
);

    localparam int GRANT_W = grant_w(NUM_REQ);
    localparam int CNT_W   = cnt_w(MIN_RUN, HALT_TIMEOUT);

    localparam logic [CNT_W-1:0]   TO_LAST  = CNT_W'(HALT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   RUN_LOAD = CNT_W'(MIN_RUN - 1);
    localparam logic [GRANT_W-1:0] PTR_LAST = GRANT_W'(NUM_REQ - 1);

    // -------------------------------------------------------------------------
    // State and datapath registers (q) with their next values (d)
    // -------------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;    // BREAK: timeout count, HOLD: run window
    logic [GRANT_W-1:0] ptr_q,   ptr_d;    // round-robin priority pointer
    logic [GRANT_W-1:0] gid_q,   gid_d;    // latched winner
    logic               err_q,   err_d;
    logic               first_q, first_d;  // first cycle of RESUME

    logic               arb_any;
    logic [GRANT_W-1:0] arb_idx;
    logic [GRANT_W-1:0] ptr_next;

    rr_arbiter #(
        .N   (NUM_REQ)
    ) u_arb (
        .req (req),
        .ptr (ptr_q),
        .any (arb_any),
        .idx (arb_idx)
    );

    // The pointer always moves just past the source that was granted, both
    // after service and after an aborted break, so a stuck source cannot
    // monopolise the scheduler.
    assign ptr_next = (gid_q == PTR_LAST) ? '0 : gid_q + GRANT_W'(1);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gid_q   <= '0;
            err_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        // A timeout in the same cycle overrides this clear below.
        err_d   = err_q & ~err_clr;
        first_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    gid_d   = arb_idx;
                    cnt_d   = '0;
                    state_d = ST_BREAK;
                end
            end

            ST_BREAK: begin
                if (halted) begin
                    cnt_d   = '0;
                    state_d = ST_SERVICE;
                end else if (cnt_q == TO_LAST) begin
                    // Core never stopped: abandon this source, still enforce
                    // the run window before trying anything else.
                    err_d   = 1'b1;
                    ptr_d   = ptr_next;
                    cnt_d   = RUN_LOAD;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_SERVICE: begin
                if (svc_done) begin
                    ptr_d   = ptr_next;
                    first_d = 1'b1;
                    state_d = ST_RESUME;
                end
            end

            ST_RESUME: begin
                // Wait for the core to actually leave the halted state so the
                // run window measures real execution time.
                if (!halted) begin
                    cnt_d   = RUN_LOAD;
                    state_d = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                // Unreachable encodings recover to a clean idle.
                state_d = ST_IDLE;
                cnt_d   = '0;
                gid_d   = '0;
                err_d   = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs: decoded from registered state only, so they are glitch-free
    // and 0 in any illegal state.
    // -------------------------------------------------------------------------
    always_comb begin
        break_out   = 1'b0;
        grant_valid = 1'b0;
        busy        = 1'b0;
        turn2run    = 1'b0;
        case (state_q)
            ST_BREAK: begin
                break_out = 1'b1;
                busy      = 1'b1;
            end
            ST_SERVICE: begin
                break_out   = 1'b1;
                grant_valid = 1'b1;
                busy        = 1'b1;
            end
            ST_RESUME: begin
                busy     = 1'b1;
                turn2run = first_q;
            end
            ST_HOLD: begin
                busy = 1'b1;
            end
            default: begin
                break_out   = 1'b0;
                grant_valid = 1'b0;
                busy        = 1'b0;
                turn2run    = 1'b0;
            end
        endcase
    end

    assign grant_id    = gid_q;
    assign timeout_err = err_q;
    assign debug_state = state_q;

endmodule

// File: tb/tb_break_sched.sv
// -----------------------------------------------------------------------------
// tb_break_sched
// Directed bench for break_sched (NUM_REQ=4, MIN_RUN=16, HALT_TIMEOUT=8).
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// at the same point, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_break_sched;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_BREAK   = 3'd1;
    localparam logic [2:0] S_SERVICE = 3'd2;
    localparam logic [2:0] S_RESUME  = 3'd3;
    localparam logic [2:0] S_HOLD    = 3'd4;

    logic       clk;
    logic       resetn;
    logic [3:0] req;
    logic       halted;
    logic       svc_done;
    logic       err_clr;
    logic       break_out;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       turn2run;
    logic       busy;
    logic       timeout_err;
    logic [2:0] debug_state;

    int tests = 0;
    int fails = 0;

    break_sched #(
        .NUM_REQ      (4),
        .MIN_RUN      (16),
        .HALT_TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req         (req),
        .halted      (halted),
        .svc_done    (svc_done),
        .err_clr     (err_clr),
        .break_out   (break_out),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .turn2run    (turn2run),
        .busy        (busy),
        .timeout_err (timeout_err),
        .debug_state (debug_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete break/service/resume/hold sequence started from IDLE.
    // halted rises 3 cycles after break_out, svc_done 5 cycles after halted.
    task automatic do_seq(input string tag, input logic [3:0] r,
                          input logic [1:0] exp_gid, input bit drop);
        req = r;
        tick();
        check({tag, " break state"}, debug_state, S_BREAK);
        check({tag, " break_out"}, break_out, 1'b1);
        check({tag, " break gid"}, grant_id, exp_gid);
        if (drop) req = 4'b0000;
        repeat (3) tick();
        halted = 1'b1;
        tick();
        check({tag, " service state"}, debug_state, S_SERVICE);
        check({tag, " grant_valid"}, grant_valid, 1'b1);
        check({tag, " service gid"}, grant_id, exp_gid);
        repeat (4) tick();
        svc_done = 1'b1;
        tick();
        svc_done = 1'b0;
        check({tag, " resume state"}, debug_state, S_RESUME);
        check({tag, " turn2run pulse"}, turn2run, 1'b1);
        check({tag, " grant_valid drop"}, grant_valid, 1'b0);
        check({tag, " break_out drop"}, break_out, 1'b0);
        halted = 1'b0;
        tick();
        check({tag, " hold state"}, debug_state, S_HOLD);
        check({tag, " turn2run single"}, turn2run, 1'b0);
        // Stray svc_done in HOLD must not disturb anything.
        for (int i = 0; i < 15; i++) begin
            svc_done = (i == 4);
            tick();
        end
        svc_done = 1'b0;
        check({tag, " hold end state"}, debug_state, S_HOLD);
        check({tag, " hold grant_valid"}, grant_valid, 1'b0);
        tick();
        check({tag, " idle state"}, debug_state, S_IDLE);
        check({tag, " idle busy"}, busy, 1'b0);
    endtask

    initial begin
        resetn   = 1'b0;
        req      = 4'b0000;
        halted   = 1'b0;
        svc_done = 1'b0;
        err_clr  = 1'b0;
        tick();
        tick();

        // ---- reset state ----
        check("rst break_out", break_out, 1'b0);
        check("rst grant_valid", grant_valid, 1'b0);
        check("rst grant_id", grant_id, 2'd0);
        check("rst turn2run", turn2run, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst timeout_err", timeout_err, 1'b0);
        check("rst state", debug_state, S_IDLE);
        resetn = 1'b1;
        tick();
        check("idle no req", debug_state, S_IDLE);

        // ---- single request, source 2 (pointer ends at 3) ----
        do_seq("single", 4'b0100, 2'd2, 1'b1);

        // ---- halt timeout, source 0 only (pointer ends at 1) ----
        req = 4'b0001;
        tick();
        check("to break_out", break_out, 1'b1);
        check("to gid", grant_id, 2'd0);
        req = 4'b0000;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("to still breaking", break_out, 1'b1);
        end
        tick();
        check("to break_out drop", break_out, 1'b0);
        check("to state hold", debug_state, S_HOLD);
        check("to err set", timeout_err, 1'b1);
        check("to no grant", grant_valid, 1'b0);
        check("to no turn2run", turn2run, 1'b0);
        repeat (15) tick();
        check("to hold end", debug_state, S_HOLD);
        tick();
        check("to idle", debug_state, S_IDLE);
        check("to err sticky", timeout_err, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("to err cleared", timeout_err, 1'b0);

        // ---- run window: source 1 re-requests right after turn2run ----
        req = 4'b0010;
        tick();
        check("rw gid", grant_id, 2'd1);
        req = 4'b0000;
        repeat (3) tick();
        halted = 1'b1;
        tick();
        check("rw service", debug_state, S_SERVICE);
        svc_done = 1'b1;
        tick();
        svc_done = 1'b0;
        check("rw turn2run", turn2run, 1'b1);
        req    = 4'b0010;
        halted = 1'b0;
        tick();
        check("rw hold", debug_state, S_HOLD);
        for (int i = 0; i < 16; i++) begin
            tick();
            check("rw window break_out", break_out, 1'b0);
        end
        tick();
        check("rw rebreak", break_out, 1'b1);
        check("rw rebreak gid", grant_id, 2'd1);
        req = 4'b0000;
        repeat (2) tick();
        halted = 1'b1;
        tick();
        check("rst-svc grant_valid", grant_valid, 1'b1);

        // ---- reset in the middle of SERVICE ----
        resetn = 1'b0;
        #1;
        check("rst-svc break_out", break_out, 1'b0);
        check("rst-svc grant_valid low", grant_valid, 1'b0);
        check("rst-svc state", debug_state, S_IDLE);
        tick();
        check("rst-svc edge break_out", break_out, 1'b0);
        check("rst-svc edge gid", grant_id, 2'd0);
        halted = 1'b0;
        resetn = 1'b1;
        tick();

        // ---- round robin: all sources held, pointer back at 0 ----
        do_seq("rr0", 4'b1111, 2'd0, 1'b0);
        do_seq("rr1", 4'b1111, 2'd1, 1'b0);
        do_seq("rr2", 4'b1111, 2'd2, 1'b0);
        do_seq("rr3", 4'b1111, 2'd3, 1'b0);
        do_seq("rr4 wrap", 4'b1111, 2'd0, 1'b1);

        // ---- withdrawal during BREAK, source 3 ----
        do_seq("withdraw", 4'b1000, 2'd3, 1'b1);

        // ---- stray svc_done in IDLE ----
        svc_done = 1'b1;
        tick();
        svc_done = 1'b0;
        check("stray idle state", debug_state, S_IDLE);
        check("stray idle grant_valid", grant_valid, 1'b0);
        check("stray idle turn2run", turn2run, 1'b0);
        tick();
        check("stray idle break_out", break_out, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
